// File: rtl/vend_pkg.sv
// Shared types and constants for the coin vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int unsigned VALUE_W = 3;

    localparam logic [VALUE_W-1:0] NICKEL_V  = 3'd1;
    localparam logic [VALUE_W-1:0] DIME_V    = 3'd2;
    localparam logic [VALUE_W-1:0] QUARTER_V = 3'd5;

endpackage

// File: rtl/coin_decode.sv
// Combinational coin decoder: flags a single valid coin or a multi-coin
// collision and gives the coin value in nickel units.
module coin_decode
    import vend_pkg::*;
(
    input  logic               coin_n,
    input  logic               coin_d,
    input  logic               coin_q,
    output logic               valid,
    output logic               multi,
    output logic [VALUE_W-1:0] value
);

    logic [1:0] n_high;

    always_comb begin
        n_high = 2'(coin_n) + 2'(coin_d) + 2'(coin_q);
        valid  = (n_high == 2'd1);
        multi  = (n_high >= 2'd2);
        value  = '0;
        if (coin_n)      value = NICKEL_V;
        else if (coin_d) value = DIME_V;
        else if (coin_q) value = QUARTER_V;
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: accumulates credit, pulses vend at PRICE,
// then pays change or a cancel refund out one nickel per cycle.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_n,
    input  logic                coin_d,
    input  logic                coin_q,
    input  logic                cancel,
    output logic                vend,
    output logic                nickel_out,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    // Credit must hold PRICE plus a quarter's worth of overshoot.
    generate
        if (PRICE < 1 || (PRICE + 4) > ((2 ** CREDIT_W) - 1)) begin : g_bad_params
            $error("vend_ctrl_param: PRICE out of range for CREDIT_W");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic               coin_valid;
    logic               coin_multi;
    logic [VALUE_W-1:0] coin_value;

    coin_decode u_coin_decode (
        .coin_n (coin_n),
        .coin_d (coin_d),
        .coin_q (coin_q),
        .valid  (coin_valid),
        .multi  (coin_multi),
        .value  (coin_value)
    );

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] sum;
    logic                rej_d;
    logic                any_coin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            vend       <= 1'b0;
            nickel_out <= 1'b0;
            coin_rej   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            vend       <= (state_d == VEND);
            nickel_out <= (state_d == CHANGE);
            coin_rej   <= rej_d;
            busy       <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        rej_d    = 1'b0;
        any_coin = coin_n | coin_d | coin_q;
        sum      = credit_q + CREDIT_W'(coin_value);

        case (state_q)
            IDLE, COLLECT: begin
                // Cancel beats a simultaneous coin; the coin goes back.
                if (cancel && state_q == COLLECT && credit_q != '0) begin
                    state_d = CHANGE;
                    rej_d   = any_coin;
                end else if (coin_multi) begin
                    rej_d = 1'b1;
                end else if (coin_valid) begin
                    if (sum >= PRICE_C) begin
                        state_d  = VEND;
                        credit_d = sum - PRICE_C;
                    end else begin
                        state_d  = COLLECT;
                        credit_d = sum;
                    end
                end
            end
            VEND: begin
                rej_d   = any_coin;
                state_d = (credit_q == '0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                rej_d = any_coin;
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d  = IDLE;
                    credit_d = '0;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign credit = credit_q;
    assign state  = state_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed self-checking bench for vend_ctrl_param at PRICE=4 and PRICE=7.
module tb_vend_ctrl_param;

    logic clk = 1'b0;
    logic rst;
    logic cn, cd, cq, cc;
    logic c7n, c7d, c7q, c7c;

    logic       v4, n4, r4, b4;
    logic [3:0] cr4;
    logic [1:0] st4;
    logic       v7, n7, r7, b7;
    logic [3:0] cr7;
    logic [1:0] st7;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vend_ctrl_param #(.PRICE(4), .CREDIT_W(4)) dut4 (
        .clk(clk), .rst(rst), .coin_n(cn), .coin_d(cd), .coin_q(cq), .cancel(cc),
        .vend(v4), .nickel_out(n4), .coin_rej(r4), .busy(b4), .credit(cr4), .state(st4)
    );

    vend_ctrl_param #(.PRICE(7), .CREDIT_W(4)) dut7 (
        .clk(clk), .rst(rst), .coin_n(c7n), .coin_d(c7d), .coin_q(c7q), .cancel(c7c),
        .vend(v7), .nickel_out(n7), .coin_rej(r7), .busy(b7), .credit(cr7), .state(st7)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check every PRICE=4 output: state, credit, vend, nickel_out, coin_rej, busy.
    task automatic exp4(input string tag, input int st, input int cr, input int v,
                        input int n, input int rej, input int b);
        chk({tag, "_state"},  int'(st4), st);
        chk({tag, "_credit"}, int'(cr4), cr);
        chk({tag, "_vend"},   int'(v4),  v);
        chk({tag, "_nickel"}, int'(n4),  n);
        chk({tag, "_rej"},    int'(r4),  rej);
        chk({tag, "_busy"},   int'(b4),  b);
    endtask

    task automatic exp7(input string tag, input int st, input int cr, input int v, input int n);
        chk({tag, "_state7"},  int'(st7), st);
        chk({tag, "_credit7"}, int'(cr7), cr);
        chk({tag, "_vend7"},   int'(v7),  v);
        chk({tag, "_nickel7"}, int'(n7),  n);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cn = 1'b0; cd = 1'b0; cq = 1'b0; cc = 1'b0;
        c7n = 1'b0; c7d = 1'b0; c7q = 1'b0; c7c = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cn = 1'b0; cd = 1'b0; cq = 1'b0; cc = 1'b0;
        c7n = 1'b0; c7d = 1'b0; c7q = 1'b0; c7c = 1'b0;
        #12;
        exp4("reset", 0, 0, 0, 0, 0, 0);
        exp7("reset", 0, 0, 0, 0);
        rst = 1'b1;

        // N,N,N,N: exact price, no change
        cn = 1'b1; tick; exp4("nnnn1", 1, 1, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("nnnn2", 1, 2, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("nnnn3", 1, 3, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("nnnn4", 2, 0, 1, 0, 0, 1);
        tick;            exp4("nnnn_end", 0, 0, 0, 0, 0, 0);

        // D,N,D: one nickel of change
        cd = 1'b1; tick; exp4("dnd1", 1, 2, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("dnd2", 1, 3, 0, 0, 0, 0);
        cd = 1'b1; tick; exp4("dnd3", 2, 1, 1, 0, 0, 1);
        tick;            exp4("dnd_chg", 3, 1, 0, 1, 0, 1);
        tick;            exp4("dnd_end", 0, 0, 0, 0, 0, 0);

        // Single quarter
        cq = 1'b1; tick; exp4("q1", 2, 1, 1, 0, 0, 1);
        tick;            exp4("q_chg", 3, 1, 0, 1, 0, 1);
        tick;            exp4("q_end", 0, 0, 0, 0, 0, 0);

        // PRICE=7, Q,Q: three nickels of change back to back
        c7q = 1'b1; tick; exp7("p7q1", 1, 5, 0, 0);
        c7q = 1'b1; tick; exp7("p7q2", 2, 3, 1, 0);
        tick;             exp7("p7c3", 3, 3, 0, 1);
        tick;             exp7("p7c2", 3, 2, 0, 1);
        tick;             exp7("p7c1", 3, 1, 0, 1);
        tick;             exp7("p7end", 0, 0, 0, 0);

        // D then cancel: full refund of two nickels
        cd = 1'b1; tick; exp4("dc1", 1, 2, 0, 0, 0, 0);
        cc = 1'b1; tick; exp4("dc_cancel", 3, 2, 0, 1, 0, 1);
        tick;            exp4("dc_chg2", 3, 1, 0, 1, 0, 1);
        tick;            exp4("dc_end", 0, 0, 0, 0, 0, 0);

        // Cancel in IDLE does nothing
        cc = 1'b1; tick; exp4("idle_cancel", 0, 0, 0, 0, 0, 0);

        // Two coins at once: rejected, credit kept
        cn = 1'b1; tick; exp4("multi_pre", 1, 1, 0, 0, 0, 0);
        cn = 1'b1; cd = 1'b1; tick; exp4("multi_rej", 1, 1, 0, 0, 1, 0);
        tick;            exp4("multi_after", 1, 1, 0, 0, 0, 0);
        cc = 1'b1; tick; exp4("multi_cancel", 3, 1, 0, 1, 0, 1);
        tick;            exp4("multi_end", 0, 0, 0, 0, 0, 0);

        // Cancel with a coin in COLLECT: cancel wins, coin rejected
        cn = 1'b1; tick; exp4("cc_pre", 1, 1, 0, 0, 0, 0);
        cc = 1'b1; cq = 1'b1; tick; exp4("cc_coin", 3, 1, 0, 1, 1, 1);
        tick;            exp4("cc_end", 0, 0, 0, 0, 0, 0);

        // Coin during CHANGE: rejected, payout count unchanged
        cd = 1'b1; tick; exp4("chgc1", 1, 2, 0, 0, 0, 0);
        cq = 1'b1; tick; exp4("chgc_vend", 2, 3, 1, 0, 0, 1);
        tick;            exp4("chgc_c3", 3, 3, 0, 1, 0, 1);
        cn = 1'b1; tick; exp4("chgc_c2", 3, 2, 0, 1, 1, 1);
        tick;            exp4("chgc_c1", 3, 1, 0, 1, 0, 1);
        tick;            exp4("chgc_end", 0, 0, 0, 0, 0, 0);

        // Async reset mid-CHANGE, then a normal purchase
        cd = 1'b1; tick; exp4("rm1", 1, 2, 0, 0, 0, 0);
        cq = 1'b1; tick; exp4("rm_vend", 2, 3, 1, 0, 0, 1);
        tick;            exp4("rm_chg", 3, 3, 0, 1, 0, 1);
        #2 rst = 1'b0;
        #1;              exp4("rm_async", 0, 0, 0, 0, 0, 0);
        tick;            exp4("rm_hold", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        cn = 1'b1; tick; exp4("rr1", 1, 1, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("rr2", 1, 2, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("rr3", 1, 3, 0, 0, 0, 0);
        cn = 1'b1; tick; exp4("rr4", 2, 0, 1, 0, 0, 1);
        tick;            exp4("rr_end", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
